// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/divide unit.
// Holds the unit's state encoding and the latched operation flag values.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_ITER = 3'd1,
    DIV_ITER = 3'd2,
    FIXUP    = 3'd3,
    DZERO    = 3'd4
  } md_state_t;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negation: magnitude extraction or result sign fix.
module md_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  // Negate when requested, pass through otherwise
  always_comb begin
    if (negate) begin
      result = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider feeding the CPU HI/LO registers.
// Works on operand magnitudes; the sign is restored in a single FIXUP cycle.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  md_state_t          stateR, nextStateS;
  logic               opR, negResR, negRemR;
  logic [WIDTH-1:0]   mcandR;
  logic [2*WIDTH-1:0] accR;
  logic [CNT_W-1:0]   cntR;

  logic [WIDTH-1:0]   aMagS, bMagS, quoFixS, remFixS;
  logic [2*WIDTH-1:0] prodFixS;
  logic [WIDTH:0]     mulSumS, remShS, divDiffS;

  md_abs_neg #(.WIDTH(WIDTH)) uAbsA (.value(op_a), .negate(sign_mode & op_a[WIDTH-1]), .result(aMagS));
  md_abs_neg #(.WIDTH(WIDTH)) uAbsB (.value(op_b), .negate(sign_mode & op_b[WIDTH-1]), .result(bMagS));

  // Result correction: full product, or quotient and remainder with independent signs
  md_abs_neg #(.WIDTH(2*WIDTH)) uFixProd (.value(accR), .negate(negResR), .result(prodFixS));
  md_abs_neg #(.WIDTH(WIDTH)) uFixQuo (.value(accR[WIDTH-1:0]), .negate(negResR), .result(quoFixS));
  md_abs_neg #(.WIDTH(WIDTH)) uFixRem (.value(accR[2*WIDTH-1:WIDTH]), .negate(negRemR), .result(remFixS));

  // Per-iteration arithmetic for both algorithms
  always_comb begin
    mulSumS  = {1'b0, accR[2*WIDTH-1:WIDTH]} + {1'b0, mcandR};
    remShS   = {accR[2*WIDTH-1:WIDTH], accR[WIDTH-1]};
    divDiffS = remShS - {1'b0, mcandR};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state logic; start_mult wins over start_div, starts outside IDLE are dropped
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (start_mult) begin
          nextStateS = MUL_ITER;
        end else if (start_div) begin
          nextStateS = (op_b == {WIDTH{1'b0}}) ? DZERO : DIV_ITER;
        end else begin
          nextStateS = IDLE;
        end
      end
      MUL_ITER, DIV_ITER: begin
        if (cntR == CNT_ONE) begin
          nextStateS = FIXUP;
        end else begin
          nextStateS = stateR;
        end
      end
      FIXUP, DZERO: nextStateS = IDLE;
      default:      nextStateS = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      opR      <= MD_OP_MULT;
      negResR  <= 1'b0;
      negRemR  <= 1'b0;
      mcandR   <= {WIDTH{1'b0}};
      accR     <= {(2*WIDTH){1'b0}};
      cntR     <= {CNT_W{1'b0}};
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (stateR)
        IDLE: begin
          if (start_mult || start_div) begin
            busy    <= 1'b1;
            cntR    <= CNT_LOAD;
            opR     <= start_mult ? MD_OP_MULT : MD_OP_DIV;
            negResR <= sign_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            negRemR <= sign_mode & op_a[WIDTH-1];
            if (start_mult) begin
              mcandR <= aMagS;
              accR   <= {{WIDTH{1'b0}}, bMagS};
            end else begin
              mcandR <= bMagS;
              accR   <= {{WIDTH{1'b0}}, aMagS};
            end
          end
        end
        MUL_ITER: begin
          cntR <= cntR - CNT_ONE;
          if (accR[0]) begin
            accR <= {mulSumS, accR[WIDTH-1:1]};
          end else begin
            accR <= {1'b0, accR[2*WIDTH-1:1]};
          end
        end
        DIV_ITER: begin
          cntR <= cntR - CNT_ONE;
          // Restore (keep shifted remainder) when the trial subtraction underflows
          if (divDiffS[WIDTH]) begin
            accR <= {remShS[WIDTH-1:0], accR[WIDTH-2:0], 1'b0};
          end else begin
            accR <= {divDiffS[WIDTH-1:0], accR[WIDTH-2:0], 1'b1};
          end
        end
        FIXUP: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (opR == MD_OP_MULT) begin
            hi <= prodFixS[2*WIDTH-1:WIDTH];
            lo <= prodFixS[WIDTH-1:0];
          end else begin
            hi <= remFixS;
            lo <= quoFixS;
          end
        end
        DZERO: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= 1'b1;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized ops against
// an arithmetic reference model (64-bit integer multiply, divide and modulo).
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start_mult, start_div, sign_mode;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] expHi = '0, expLo = '0;

  typedef struct {
    bit           m;
    bit           s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .sign_mode(sign_mode), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: signed/unsigned arithmetic on 64-bit integers, truncated to HI/LO
  function automatic void refCalc(input bit isMul, input bit sgn, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] rHi,
                                  output logic [W-1:0] rLo);
    longint sa, sb;
    logic [63:0] p;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    if (isMul) begin
      p = 64'(sa * sb);
      rHi = p[63:32];
      rLo = p[31:0];
    end else begin
      p = 64'(sa / sb);
      rLo = p[31:0];
      p = 64'(sa % sb);
      rHi = p[31:0];
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // One-cycle start pulse at edge E0; operands are scrambled afterwards
  task automatic issue(input bit m, input bit d, input bit s, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    start_mult = m; start_div = d; sign_mode = s; op_a = a; op_b = b;
    tick();
    start_mult = 1'b0; start_div = 1'b0; sign_mode = ~s;
    op_a = 32'($urandom()); op_b = 32'($urandom());
  endtask

  // Bounded wait for done; lat is the edge number (from E0) of the done edge, -1 on timeout
  task automatic waitDone(input int startEdge, output int lat, output bit dz, output bit busyOk);
    lat = -1; dz = 1'b0; busyOk = 1'b1;
    for (int n = startEdge + 1; n <= 200; n++) begin
      tick();
      if (done) begin
        lat = n;
        dz = div_zero;
        if (busy) busyOk = 1'b0;
        return;
      end else if (!busy) begin
        busyOk = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; sign_mode = 1'b0;
    op_a = '0; op_b = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({busy, done, div_zero} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: busy/done/div_zero=%b expected 000", {busy, done, div_zero});
    end
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
  endtask

  task automatic test_directed();
    vec_t dv[7];
    int lat; bit dz, bOk;
    dv = '{
      '{1'b1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
      '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE},
      '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{1'b0, 1'b0, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003},
      '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{1'b0, 1'b0, 32'h0000_0005, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002}
    };
    for (int i = 0; i < 7; i++) begin
      issue(dv[i].m, !dv[i].m, dv[i].s, dv[i].a, dv[i].b);
      waitDone(0, lat, dz, bOk);
      vectors++;
      if (lat !== W + 1 || dz !== 1'b0 || bOk !== 1'b1) begin
        miscompares++;
        $display("FAIL dir_timing[%0d]: lat=%0d dz=%b busyOk=%b expected %0d/0/1", i, lat, dz, bOk, W + 1);
      end
      vectors++;
      if (hi !== dv[i].eh || lo !== dv[i].el) begin
        miscompares++;
        $display("FAIL dir_result[%0d]: hi=%h lo=%h expected %h %h", i, hi, lo, dv[i].eh, dv[i].el);
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL dir_done_width[%0d]: done=%b one cycle later, expected 0", i, done);
      end
      expHi = dv[i].eh; expLo = dv[i].el;
    end
  endtask

  // Relies on hi=1, lo=2 left by the last directed vector
  task automatic test_div_zero();
    int lat; bit dz, bOk;
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000);
    waitDone(0, lat, dz, bOk);
    vectors++;
    if (lat !== 1 || dz !== 1'b1 || bOk !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_pulse: lat=%0d div_zero=%b busyOk=%b expected 1/1/1", lat, dz, bOk);
    end
    vectors++;
    if (hi !== 32'h1 || lo !== 32'h2) begin
      miscompares++;
      $display("FAIL dz_hold: hi=%h lo=%h expected 00000001 00000002", hi, lo);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_width: done=%b div_zero=%b next cycle, expected 0/0", done, div_zero);
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit dz, bOk, s;
    logic [W-1:0] a, b, eh, el;
    s = 1'($urandom_range(0, 1)); a = 32'($urandom()); b = 32'($urandom());
    refCalc(1'b1, s, a, b, eh, el);
    issue(1'b1, 1'b0, s, a, b);
    repeat (9) tick();
    start_div = 1'b1; op_a = 32'h0000_0009; op_b = 32'h0000_0003; sign_mode = ~s;
    tick();
    start_div = 1'b0;
    waitDone(10, lat, dz, bOk);
    vectors++;
    if (lat !== W + 1 || hi !== eh || lo !== el) begin
      miscompares++;
      $display("FAIL busy_start: lat=%0d hi=%h lo=%h expected %0d %h %h", lat, hi, lo, W + 1, eh, el);
    end
    a = 32'($urandom_range(1, 5000)); b = 32'($urandom_range(1, 5000));
    refCalc(1'b1, 1'b0, a, b, eh, el);
    issue(1'b1, 1'b1, 1'b0, a, b);
    waitDone(0, lat, dz, bOk);
    vectors++;
    if (lat !== W + 1 || hi !== eh || lo !== el) begin
      miscompares++;
      $display("FAIL both_starts: lat=%0d hi=%h lo=%h expected %0d %h %h", lat, hi, lo, W + 1, eh, el);
    end
    expHi = eh; expLo = el;
  endtask

  task automatic test_random();
    int lat, eLat; bit dz, bOk, eDz, m, s;
    logic [W-1:0] a, b, eh, el;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      a = pick(); b = pick();
      if (!m && b == 32'h0) begin
        eLat = 1; eDz = 1'b1; eh = expHi; el = expLo;
      end else begin
        eLat = W + 1; eDz = 1'b0;
        refCalc(m, s, a, b, eh, el);
      end
      issue(m, !m, s, a, b);
      waitDone(0, lat, dz, bOk);
      vectors++;
      if (lat !== eLat || dz !== eDz || bOk !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd_timing[%0d]: lat=%0d dz=%b busyOk=%b expected %0d/%b/1", i, lat, dz, bOk, eLat, eDz);
      end
      vectors++;
      if (hi !== eh || lo !== el) begin
        miscompares++;
        $display("FAIL rnd_result[%0d] m=%b s=%b a=%h b=%h: hi=%h lo=%h expected %h %h",
                 i, m, s, a, b, hi, lo, eh, el);
      end
      expHi = eh; expLo = el;
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit dz, bOk, sawDone;
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0002);
    waitDone(0, lat, dz, bOk);
    vectors++;
    if (hi !== 32'h1 || lo !== 32'h3) begin
      miscompares++;
      $display("FAIL pre_reset_div: hi=%h lo=%h expected 00000001 00000003", hi, lo);
    end
    issue(1'b0, 1'b1, 1'b1, 32'($urandom()), 32'($urandom_range(1, 1000)));
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    sawDone = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done || busy) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_discard: activity after reset=%b expected 0", sawDone);
    end
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0000_0007);
    waitDone(0, lat, dz, bOk);
    vectors++;
    if (lat !== W + 1 || hi !== 32'h0 || lo !== 32'h0000_002A) begin
      miscompares++;
      $display("FAIL post_reset_mult: lat=%0d hi=%h lo=%h expected %0d 00000000 0000002a", lat, hi, lo, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
